// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush and forwarding control for the 5-stage MIPS pipe.
// Keeps a shadow E/M/W pipeline of destination info beside the datapath.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRD,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [2:0]  Forward_RS_D_Sel,
    output logic [2:0]  Forward_RT_D_Sel,
    output logic [2:0]  Forward_RS_E_Sel,
    output logic [2:0]  Forward_RT_E_Sel,
    output logic [2:0]  Forward_RT_M_Sel,
    output logic        MDBusy
);

    localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [2:0] SEL_REG  = 3'd0;
    localparam logic [2:0] SEL_PC8E = 3'd1;
    localparam logic [2:0] SEL_AOM  = 3'd2;
    localparam logic [2:0] SEL_PC8M = 3'd3;
    localparam logic [2:0] SEL_WD   = 3'd4;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       pc8;
    } shadow_t;

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign op = IRD[31:26];
    assign rs = IRD[25:21];
    assign rt = IRD[20:16];
    assign rd = IRD[15:11];
    assign fn = IRD[5:0];
    assign unused_shamt = ^IRD[10:6];

    logic is_r;
    logic i_alu;
    logic i_jr;
    logic i_mul;
    logic i_div;
    logic i_mf;
    logic i_mt;
    logic i_ori;
    logic i_lui;
    logic i_lw;
    logic i_sw;
    logic i_beq;
    logic i_jal;
    logic md_cls;

    assign is_r   = (op == 6'h00);
    assign i_alu  = is_r & ((fn == 6'h21) | (fn == 6'h23));
    assign i_jr   = is_r & (fn == 6'h08);
    assign i_mul  = is_r & ((fn == 6'h18) | (fn == 6'h19));
    assign i_div  = is_r & ((fn == 6'h1a) | (fn == 6'h1b));
    assign i_mf   = is_r & ((fn == 6'h10) | (fn == 6'h12));
    assign i_mt   = is_r & ((fn == 6'h11) | (fn == 6'h13));
    assign i_ori  = (op == 6'h0d);
    assign i_lui  = (op == 6'h0f);
    assign i_lw   = (op == 6'h23);
    assign i_sw   = (op == 6'h2b);
    assign i_beq  = (op == 6'h04);
    assign i_jal  = (op == 6'h03);
    assign md_cls = i_mul | i_div | i_mf | i_mt;

    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    shadow_t    dec;

    // Tuse of 3 marks an operand the instruction never reads.
    always_comb begin
        tuse_rs = 2'd3;
        unique case (1'b1)
            i_beq, i_jr: tuse_rs = 2'd0;
            i_alu, i_ori, i_lw, i_sw, i_mul, i_div, i_mt: tuse_rs = 2'd1;
            default: ;
        endcase
        tuse_rt = 2'd3;
        unique case (1'b1)
            i_beq: tuse_rt = 2'd0;
            i_alu, i_mul, i_div: tuse_rt = 2'd1;
            i_sw: tuse_rt = 2'd2;
            default: ;
        endcase
    end

    always_comb begin
        dec = '0;
        unique case (1'b1)
            i_alu, i_mf: dec.a3 = rd;
            i_ori, i_lui, i_lw: dec.a3 = rt;
            i_jal: dec.a3 = 5'd31;
            default: ;
        endcase
        unique case (1'b1)
            i_alu, i_ori, i_lui, i_mf: dec.tnew = 2'd1;
            i_lw: dec.tnew = 2'd2;
            default: ;
        endcase
        dec.pc8 = i_jal;
    end

    shadow_t       sh_e;
    shadow_t       sh_m;
    shadow_t       sh_w;
    logic [4:0]    rs_e;
    logic [4:0]    rt_e;
    logic [4:0]    rt_m;
    logic          sw_e;
    logic          md_start_e;
    logic          md_div_e;
    logic [CW-1:0] cnt;

    function automatic logic raw_hit(input logic [4:0] r,
                                     input logic [1:0] tuse,
                                     input shadow_t s);
        return (s.a3 != 5'd0) && (s.a3 == r) && (tuse < s.tnew);
    endfunction

    function automatic logic fwd_hit(input logic [4:0] r, input shadow_t s);
        return (s.a3 != 5'd0) && (s.a3 == r) && (s.tnew == 2'd0);
    endfunction

    function automatic logic [2:0] sel_late(input logic [4:0] r,
                                            input shadow_t m,
                                            input shadow_t w);
        if (fwd_hit(r, m))
            return m.pc8 ? SEL_PC8M : SEL_AOM;
        if (fwd_hit(r, w))
            return SEL_WD;
        return SEL_REG;
    endfunction

    function automatic logic [2:0] sel_d(input logic [4:0] r,
                                         input shadow_t e,
                                         input shadow_t m,
                                         input shadow_t w);
        if (fwd_hit(r, e) && e.pc8)
            return SEL_PC8E;
        return sel_late(r, m, w);
    endfunction

    function automatic shadow_t age(input shadow_t s);
        shadow_t a;
        a = s;
        if (a.tnew != 2'd0)
            a.tnew = a.tnew - 2'd1;
        return a;
    endfunction

    logic data_stall;
    logic md_stall;
    logic stall;

    assign data_stall = raw_hit(rs, tuse_rs, sh_e) | raw_hit(rs, tuse_rs, sh_m)
                      | raw_hit(rt, tuse_rt, sh_e) | raw_hit(rt, tuse_rt, sh_m);
    assign md_stall   = md_cls & ((cnt != '0) | md_start_e);
    assign stall      = data_stall | md_stall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    assign MDBusy = (cnt != '0) | md_start_e;

    assign Forward_RS_D_Sel = sel_d(rs, sh_e, sh_m, sh_w);
    assign Forward_RT_D_Sel = sel_d(rt, sh_e, sh_m, sh_w);
    assign Forward_RS_E_Sel = sel_late(rs_e, sh_m, sh_w);
    assign Forward_RT_E_Sel = sel_late(rt_e, sh_m, sh_w);
    assign Forward_RT_M_Sel = fwd_hit(rt_m, sh_w) ? SEL_WD : SEL_REG;

    // Operand registers travel only when read, so dead fields never select.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sh_e       <= '0;
            sh_m       <= '0;
            sh_w       <= '0;
            rs_e       <= '0;
            rt_e       <= '0;
            rt_m       <= '0;
            sw_e       <= 1'b0;
            md_start_e <= 1'b0;
            md_div_e   <= 1'b0;
            cnt        <= '0;
        end else begin
            if (stall) begin
                sh_e       <= '0;
                rs_e       <= '0;
                rt_e       <= '0;
                sw_e       <= 1'b0;
                md_start_e <= 1'b0;
                md_div_e   <= 1'b0;
            end else begin
                sh_e       <= dec;
                rs_e       <= (tuse_rs != 2'd3) ? rs : 5'd0;
                rt_e       <= (tuse_rt != 2'd3) ? rt : 5'd0;
                sw_e       <= i_sw;
                md_start_e <= i_mul | i_div;
                md_div_e   <= i_div;
            end
            sh_m <= age(sh_e);
            sh_w <= age(sh_m);
            rt_m <= sw_e ? rt_e : 5'd0;
            if (md_start_e)
                cnt <= md_div_e ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            else if (cnt != '0)
                cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plan sequences plus random instruction streams
// checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] IRD;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic        MDBusy;
    logic [2:0]  fd_rs;
    logic [2:0]  fd_rt;
    logic [2:0]  fe_rs;
    logic [2:0]  fe_rt;
    logic [2:0]  fm_rt;

    hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .IRD(IRD),
        .StallF(StallF),
        .StallD(StallD),
        .FlushE(FlushE),
        .Forward_RS_D_Sel(fd_rs),
        .Forward_RT_D_Sel(fd_rt),
        .Forward_RS_E_Sel(fe_rs),
        .Forward_RT_E_Sel(fe_rt),
        .Forward_RT_M_Sel(fm_rt),
        .MDBusy(MDBusy)
    );

    always #5 Clk = ~Clk;

    typedef enum int {
        K_NOP, K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL,
        K_JR, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO
    } kind_e;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          md_s = -1000;
    int          md_len = 0;
    int          dut_stalls = 0;
    logic [31:0] pipe [3];
    logic [31:0] prog [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] rins(input logic [5:0] f, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] m);
        return {o, s, t, m};
    endfunction

    function automatic kind_e kind_of(input logic [31:0] i);
        case (i[31:26])
            6'h00: begin
                case (i[5:0])
                    6'h21: return K_ADDU;
                    6'h23: return K_SUBU;
                    6'h08: return K_JR;
                    6'h18: return K_MULT;
                    6'h19: return K_MULTU;
                    6'h1a: return K_DIV;
                    6'h1b: return K_DIVU;
                    6'h10: return K_MFHI;
                    6'h12: return K_MFLO;
                    6'h11: return K_MTHI;
                    6'h13: return K_MTLO;
                    default: return K_NOP;
                endcase
            end
            6'h0d: return K_ORI;
            6'h0f: return K_LUI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int dest(input logic [31:0] i);
        case (kind_of(i))
            K_ADDU, K_SUBU, K_MFHI, K_MFLO: return int'(i[15:11]);
            K_ORI, K_LUI, K_LW: return int'(i[20:16]);
            K_JAL: return 31;
            default: return 0;
        endcase
    endfunction

    function automatic int tnew0(input logic [31:0] i);
        case (kind_of(i))
            K_ADDU, K_SUBU, K_ORI, K_LUI, K_MFHI, K_MFLO: return 1;
            K_LW: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int tuse(input logic [31:0] i, input bit use_rt);
        kind_e k = kind_of(i);
        if (!use_rt) begin
            if (k inside {K_BEQ, K_JR}) return 0;
            if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MULT, K_MULTU,
                          K_DIV, K_DIVU, K_MTHI, K_MTLO}) return 1;
            return 3;
        end
        if (k == K_BEQ) return 0;
        if (k inside {K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU}) return 1;
        if (k == K_SW) return 2;
        return 3;
    endfunction

    function automatic bit is_mdclass(input logic [31:0] i);
        return kind_of(i) inside {K_MULT, K_MULTU, K_DIV, K_DIVU,
                                  K_MFHI, K_MFLO, K_MTHI, K_MTLO};
    endfunction

    function automatic bit is_mdstart(input logic [31:0] i);
        return kind_of(i) inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
    endfunction

    function automatic int tnew_at(input int k);
        int t = tnew0(pipe[k]) - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit fwd_ok(input int k, input int r);
        return (r != 0) && (dest(pipe[k]) == r) && (tnew_at(k) == 0);
    endfunction

    function automatic int late_sel(input int r);
        if (fwd_ok(1, r)) return (kind_of(pipe[1]) == K_JAL) ? 3 : 2;
        if (fwd_ok(2, r)) return 4;
        return 0;
    endfunction

    function automatic int d_sel(input int r);
        if (fwd_ok(0, r) && kind_of(pipe[0]) == K_JAL) return 1;
        return late_sel(r);
    endfunction

    function automatic logic [4:0] rreg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [31:0] rand_ins();
        int         k = $urandom_range(0, 19);
        logic [4:0] a = rreg();
        logic [4:0] b = rreg();
        logic [4:0] c = rreg();
        logic [15:0] m = 16'($urandom);
        if (k >= 10 && k <= 13 && $urandom_range(0, 3) != 0) k = 0;
        case (k)
            0: return rins(6'h21, a, b, c);
            1: return rins(6'h23, a, b, c);
            2: return iins(6'h0d, a, b, m);
            3: return iins(6'h0f, 5'd0, b, m);
            4: return iins(6'h23, a, b, m);
            5: return iins(6'h2b, a, b, m);
            6: return iins(6'h04, a, b, m);
            7: return {6'h02, 26'($urandom)};
            8: return {6'h03, 26'($urandom)};
            9: return rins(6'h08, a, 5'd0, 5'd0);
            10: return rins(6'h18, a, b, 5'd0);
            11: return rins(6'h19, a, b, 5'd0);
            12: return rins(6'h1a, a, b, 5'd0);
            13: return rins(6'h1b, a, b, 5'd0);
            14: return rins(6'h10, 5'd0, 5'd0, c);
            15: return rins(6'h12, 5'd0, 5'd0, c);
            16: return rins(6'h11, a, 5'd0, 5'd0);
            17: return rins(6'h13, a, 5'd0, 5'd0);
            18: return 32'd0;
            default: return {6'h3f, a, b, c, 11'($urandom)};
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = 32'd0;
        md_s = -1000;
        md_len = 0;
    endtask

    task automatic step();
        int rs_d;
        int rt_d;
        int e_rs;
        int e_rt;
        int m_rt;
        bit st;
        bit busy;
        @(negedge Clk);
        rs_d = int'(IRD[25:21]);
        rt_d = int'(IRD[20:16]);
        st = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (rs_d != 0 && dest(pipe[k]) == rs_d && tuse(IRD, 1'b0) < tnew_at(k))
                st = 1'b1;
            if (rt_d != 0 && dest(pipe[k]) == rt_d && tuse(IRD, 1'b1) < tnew_at(k))
                st = 1'b1;
        end
        busy = (cyc - md_s) >= 1 && (cyc - md_s) <= md_len;
        if (is_mdclass(IRD) && (busy || is_mdstart(pipe[0]))) st = 1'b1;
        e_rs = (tuse(pipe[0], 1'b0) != 3) ? int'(pipe[0][25:21]) : 0;
        e_rt = (tuse(pipe[0], 1'b1) != 3) ? int'(pipe[0][20:16]) : 0;
        m_rt = (kind_of(pipe[1]) == K_SW) ? int'(pipe[1][20:16]) : 0;
        check("StallF", StallF, st);
        check("StallD", StallD, st);
        check("FlushE", FlushE, st);
        check("MDBusy", MDBusy, busy || is_mdstart(pipe[0]));
        check("FwdRsD", fd_rs, d_sel(rs_d));
        check("FwdRtD", fd_rt, d_sel(rt_d));
        check("FwdRsE", fe_rs, late_sel(e_rs));
        check("FwdRtE", fe_rt, late_sel(e_rt));
        check("FwdRtM", fm_rt, fwd_ok(2, m_rt) ? 4 : 0);
        dut_stalls += int'(StallD);
        @(posedge Clk);
        if (is_mdstart(pipe[0])) begin
            md_s = cyc;
            md_len = (kind_of(pipe[0]) inside {K_DIV, K_DIVU}) ? 10 : 5;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = st ? 32'd0 : IRD;
        cyc++;
        #1;
        if (!st) begin
            if (prog.size() > 0) IRD = prog.pop_front();
            else IRD = 32'd0;
        end
    endtask

    task automatic run_prog(input string tag, input int exp_stalls);
        dut_stalls = 0;
        IRD = prog.pop_front();
        while (prog.size() > 0) step();
        repeat (14) step();
        if (exp_stalls >= 0) check(tag, dut_stalls, exp_stalls);
    endtask

    initial begin
        Reset = 1'b1;
        IRD = rins(6'h12, 5'd0, 5'd0, 5'd4);
        model_clear();
        #3;
        check("rst_StallD", StallD, 0);
        check("rst_FlushE", FlushE, 0);
        check("rst_MDBusy", MDBusy, 0);
        check("rst_FwdRsD", fd_rs, 0);
        check("rst_FwdRtM", fm_rt, 0);
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b0;
        IRD = 32'd0;

        prog = '{iins(6'h23, 5'd0, 5'd1, 16'd0), rins(6'h21, 5'd1, 5'd1, 5'd2)};
        run_prog("stalls_lw_use", 1);
        prog = '{iins(6'h0d, 5'd0, 5'd1, 16'd5), iins(6'h04, 5'd1, 5'd1, 16'd3)};
        run_prog("stalls_ori_beq", 1);
        prog = '{{6'h03, 26'h40}, rins(6'h08, 5'd31, 5'd0, 5'd0)};
        run_prog("stalls_jal_jr", 0);
        prog = '{rins(6'h21, 5'd1, 5'd2, 5'd3), iins(6'h2b, 5'd0, 5'd3, 16'd0)};
        run_prog("stalls_addu_sw", 0);
        prog = '{rins(6'h18, 5'd1, 5'd2, 5'd0), rins(6'h12, 5'd0, 5'd0, 5'd4)};
        run_prog("stalls_mult_mflo", 6);
        prog = '{rins(6'h1a, 5'd1, 5'd2, 5'd0), rins(6'h12, 5'd0, 5'd0, 5'd4)};
        run_prog("stalls_div_mflo", 11);
        prog = '{rins(6'h21, 5'd1, 5'd1, 5'd0), rins(6'h21, 5'd0, 5'd0, 5'd5)};
        run_prog("stalls_reg0", 0);

        prog = '{rins(6'h18, 5'd1, 5'd2, 5'd0), rins(6'h12, 5'd0, 5'd0, 5'd4)};
        IRD = prog.pop_front();
        repeat (3) step();
        Reset = 1'b1;
        #2;
        check("midrst_MDBusy", MDBusy, 0);
        check("midrst_StallD", StallD, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_clear();
        repeat (14) step();

        for (int n = 0; n < 1500; n++) prog.push_back(rand_ins());
        run_prog("random", -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
